cam_emu_tx: RTL

OV7670-style camera stream transmitter: generates PCLK, VSYNC, HREF and 8-bit pixel bytes for a synthetic RGB444 image from one system clock. It drives the camera-capture input path (capture block → dual-port frame buffer → VGA) in simulation and on-board bring-up without a physical camera. Output frames are 160x120 by default. Each pixel is two bytes, in the same byte order the capture block expects.

---
 rtl/cam_emu_pkg.sv | 37 +++
 rtl/cam_emu_pixel.sv | 43 ++++
 rtl/cam_emu_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cam_emu_pkg.sv
// ============================================================================
// Module      : cam_emu_pkg
// Description : Shared types and constants for the camera stream emulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } state_t;

    localparam logic [1:0] c_PAT_BARS  = 2'd0;
    localparam logic [1:0] c_PAT_GRAD  = 2'd1;
    localparam logic [1:0] c_PAT_SOLID = 2'd2;
    localparam logic [1:0] c_PAT_ADDR  = 2'd3;

    // Entry 0 is the leftmost bar.
    localparam logic [7:0][11:0] c_BAR_COLORS = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F,
        12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

    // Byte 0 carries red in the low nibble, byte 1 carries green/blue.
    function automatic logic [7:0] rgb444_byte(input logic [11:0] rgb, input logic sel);
        return sel ? rgb[7:0] : {4'h0, rgb[11:8]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cam_emu_pixel.sv
// ============================================================================
// Module      : cam_emu_pixel
// Description : Combinational test-pattern generator, one RGB444 byte out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_emu_pixel
    import cam_emu_pkg::*;
#(
    parameter int H_PIXELS = 160
) (
    input  logic [1:0]  i_pattern,
    input  logic [11:0] i_solid_color,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic        i_byte_sel,
    output logic [7:0]  o_px_byte
);

    localparam logic [11:0] c_BAR_W = 12'(H_PIXELS / 8);

    logic [11:0] w_bar_idx;
    logic [11:0] w_rgb;
    logic        w_unused_bits;

    assign w_unused_bits = ^{w_bar_idx[11:3], i_y[11:7]};

    always_comb begin
        w_bar_idx = i_x / c_BAR_W;
        w_rgb     = 12'h000;
        case (i_pattern)
            c_PAT_BARS:  w_rgb = c_BAR_COLORS[w_bar_idx[2:0]];
            c_PAT_GRAD:  w_rgb = {i_x[7:4], i_y[6:3], i_x[3:0]};
            c_PAT_SOLID: w_rgb = i_solid_color;
            default:     w_rgb = {i_y[5:0], i_x[5:0]};
        endcase
        o_px_byte = rgb444_byte(w_rgb, i_byte_sel);
    end

endmodule

`default_nettype wire

// File: rtl/cam_emu_tx.sv
// ============================================================================
// Module      : cam_emu_tx
// Description : OV7670-style PCLK/VSYNC/HREF/byte stream generator.
//               Optional macro CAM_EMU_SCROLL_EN adds horizontal scrolling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_emu_tx
    import cam_emu_pkg::*;
#(
    parameter int H_PIXELS    = 160,
    parameter int V_LINES     = 120,
    parameter int H_BLANK     = 32,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern,
    input  logic [11:0] solid_color,
    output logic        CAM_pclk,
    output logic        CAM_vsync,
    output logic        CAM_href,
    output logic [7:0]  CAM_px_data,
    output logic        frame_done
);

    localparam int             c_LINE_LEN    = 2 * H_PIXELS + H_BLANK;
    localparam int             c_CNT_W       = 16;
    localparam logic [15:0]    c_VSYNC_LAST  = 16'(VSYNC_LINES * c_LINE_LEN - 1);
    localparam logic [15:0]    c_VBACK_LAST  = 16'(V_BACK * c_LINE_LEN - 1);
    localparam logic [15:0]    c_ACTIVE_LAST = 16'(2 * H_PIXELS - 1);
    localparam logic [15:0]    c_HBLANK_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0]    c_VFRONT_LAST = 16'(V_FRONT * c_LINE_LEN - 1);
    localparam logic [11:0]    c_LAST_LINE   = 12'(V_LINES - 1);

    state_t               r_state_q, w_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [11:0]          r_line_q, w_line_d;
    logic                 r_pclk_q, w_pclk_d;
    logic                 r_vsync_q, w_vsync_d;
    logic                 r_href_q, w_href_d;
    logic [7:0]           r_data_q, w_data_d;
    logic                 r_frame_done_q, w_frame_done_d;
    logic [1:0]           r_pat_q, w_pat_d;
    logic [11:0]          r_solid_q, w_solid_d;
    logic                 w_tick;
    logic                 w_frame_end;
    logic [11:0]          w_x, w_x_pix;
    logic [7:0]           w_pix_byte;

    // All stream state advances on the clk edge where PCLK falls.
    assign w_tick = r_pclk_q;
    assign w_x    = w_cnt_d[12:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_cnt_q        <= '0;
            r_line_q       <= '0;
            r_pclk_q       <= 1'b0;
            r_vsync_q      <= 1'b0;
            r_href_q       <= 1'b0;
            r_data_q       <= 8'h00;
            r_frame_done_q <= 1'b0;
            r_pat_q        <= '0;
            r_solid_q      <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_line_q       <= w_line_d;
            r_pclk_q       <= w_pclk_d;
            r_vsync_q      <= w_vsync_d;
            r_href_q       <= w_href_d;
            r_data_q       <= w_data_d;
            r_frame_done_q <= w_frame_done_d;
            r_pat_q        <= w_pat_d;
            r_solid_q      <= w_solid_d;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_line_d    = r_line_q;
        w_frame_end = 1'b0;
        if (w_tick) begin
            w_cnt_d = r_cnt_q + 1'b1;
            case (r_state_q)
                ST_IDLE: begin
                    w_cnt_d = '0;
                    if (en) w_state_d = ST_VSYNC;
                end
                ST_VSYNC: if (r_cnt_q == c_VSYNC_LAST) begin
                    w_state_d = ST_VBACK;
                    w_cnt_d   = '0;
                end
                ST_VBACK: if (r_cnt_q == c_VBACK_LAST) begin
                    w_state_d = ST_ACTIVE;
                    w_cnt_d   = '0;
                    w_line_d  = '0;
                end
                ST_ACTIVE: if (r_cnt_q == c_ACTIVE_LAST) begin
                    w_state_d = ST_HBLANK;
                    w_cnt_d   = '0;
                end
                ST_HBLANK: if (r_cnt_q == c_HBLANK_LAST) begin
                    w_cnt_d = '0;
                    if (r_line_q == c_LAST_LINE) begin
                        w_state_d = ST_VFRONT;
                    end else begin
                        w_state_d = ST_ACTIVE;
                        w_line_d  = r_line_q + 1'b1;
                    end
                end
                ST_VFRONT: if (r_cnt_q == c_VFRONT_LAST) begin
                    w_frame_end = 1'b1;
                    w_cnt_d     = '0;
                    w_state_d   = en ? ST_VSYNC : ST_IDLE;
                end
                default: begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef CAM_EMU_SCROLL_EN
    logic [7:0] r_frame_cnt_q, w_frame_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) r_frame_cnt_q <= 8'h00;
        else     r_frame_cnt_q <= w_frame_cnt_d;
    end

    always_comb begin
        w_frame_cnt_d = r_frame_cnt_q + {7'd0, w_frame_end};
        w_x_pix       = w_x;
        if (r_pat_q == c_PAT_BARS || r_pat_q == c_PAT_GRAD)
            w_x_pix = (w_x + {4'h0, r_frame_cnt_q}) % 12'(H_PIXELS);
    end
`else
    always_comb begin
        w_x_pix = w_x;
    end
`endif

    cam_emu_pixel #(
        .H_PIXELS (H_PIXELS)
    ) u_pixel (
        .i_pattern     (r_pat_q),
        .i_solid_color (r_solid_q),
        .i_x           (w_x_pix),
        .i_y           (w_line_d),
        .i_byte_sel    (w_cnt_d[0]),
        .o_px_byte     (w_pix_byte)
    );

    // Outputs are computed from the upcoming state so they are registered, not decoded.
    always_comb begin
        w_pclk_d       = ~r_pclk_q;
        w_vsync_d      = r_vsync_q;
        w_href_d       = r_href_q;
        w_data_d       = r_data_q;
        w_frame_done_d = w_frame_end;
        w_pat_d        = r_pat_q;
        w_solid_d      = r_solid_q;
        if (w_tick) begin
            w_vsync_d = (w_state_d == ST_VSYNC);
            w_href_d  = (w_state_d == ST_ACTIVE);
            w_data_d  = (w_state_d == ST_ACTIVE) ? w_pix_byte : 8'h00;
            if (w_state_d == ST_VSYNC && r_state_q != ST_VSYNC) begin
                w_pat_d   = pattern;
                w_solid_d = solid_color;
            end
        end
    end

    assign CAM_pclk    = r_pclk_q;
    assign CAM_vsync   = r_vsync_q;
    assign CAM_href    = r_href_q;
    assign CAM_px_data = r_data_q;
    assign frame_done  = r_frame_done_q;

endmodule

`default_nettype wire
